song_sequencer: RTL
===================

SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 2_500_000, giving the clock cycles per length unit.
REQ-002 SHALL have parameter GAP_CYCLES, default 250_000, giving the silent cycles at the end of each note; constraint 0 <= GAP_CYCLES < UNIT_CYCLES.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; ports clk and rst_n are listed first.
REQ-004 clk  input  1  system clock; all state updates occur on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle play request.
REQ-007 stop  input  1  single-cycle abort request.
REQ-008 pause  input  1  level; while high, playback is held.
REQ-009 song_sel  input  `SONG_BITS  song to play, sampled on an accepted start.
REQ-010 rom_song  output  `SONG_BITS  song index driven to the song table.
REQ-011 rom_cnt  output  `SONG_CNT_BITS  note index driven to the song table.
REQ-012 rom_track, rom_octave, rom_note, rom_length  input  `SONG_CNT_BITS/`OCTAVE_BITS/`NOTE_BITS/`LENGTH_BITS  combinational table outputs.
REQ-013 tone_valid  output  1  high while a note sounds.
REQ-014 tone_octave, tone_note  output  `OCTAVE_BITS/`NOTE_BITS  registered pitch of the current note.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse when the last note's GAP completes.

Function
REQ-017 SHALL implement the states IDLE, FETCH, PLAY, GAP and END.
REQ-018 IDLE: start -> latch song_sel into rom_song, set rom_cnt=0, go to FETCH.
REQ-019 FETCH (exactly 1 cycle): if rom_cnt >= rom_track, go to END.
REQ-020 FETCH: if rom_cnt < rom_track and rom_length==0, increment rom_cnt and stay in FETCH (note skipped, no sound).
REQ-021 FETCH: otherwise, register rom_octave/rom_note, load timer = rom_length*UNIT_CYCLES - GAP_CYCLES, go to PLAY.
REQ-022 The timer SHALL be at least `LENGTH_BITS+32 bits wide so the product cannot overflow.
REQ-023 PLAY: tone_valid=1; timer decrements each unpaused cycle; on reaching 1, load timer=GAP_CYCLES and go to GAP, or go directly to FETCH with rom_cnt+1 if GAP_CYCLES==0.
REQ-024 GAP: tone_valid=0; on timer expiry, rom_cnt+1 and go to FETCH.
REQ-025 END: assert done for 1 cycle, then go to IDLE (see REQ-033).
REQ-026 pause high in PLAY/GAP: timer and state frozen, tone_valid=0; PLAY resumes with the remaining count after release.
REQ-027 pause in FETCH/END/IDLE SHALL have no effect.
REQ-028 stop in any state: next edge -> IDLE, tone_valid=0, busy=0, no done pulse.
REQ-029 stop and start in the same cycle: stop wins, sequencer stays in IDLE.
REQ-030 start while busy SHALL be ignored; changing song_sel while busy SHALL have no effect.
REQ-031 rom_track==0 SHALL go FETCH -> END immediately, pulsing done with no tone.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, timer=0, rom_song=0, rom_cnt=0, tone_valid=0, tone_octave=0, tone_note=0, busy=0, done=0, including mid-note.

Configuration
REQ-033 Macro SONG_LOOP_EN: when defined, END pulses done, resets rom_cnt=0 and goes to FETCH, repeating until stop; when undefined, END pulses done and returns to IDLE.

Verification (UNIT_CYCLES=4, GAP_CYCLES=1, real song table)
REQ-034 start with song_sel=`little_star -> tone_valid high (4*`quarter_note-1) cycles with note=`do, octave=3'b100, then 1 cycle low, then 2nd note; after 42 notes done pulses once, busy drops.
REQ-035 `two_tigers notes 27/28 -> tone_octave=3'b011; note 14 lasts 4*`sixteenth_note-1 cycles.
REQ-036 pause held 10 cycles mid-PLAY -> tone_valid low for 10 cycles, total note high time unchanged.
REQ-037 stop during note 5 -> IDLE next cycle, no done; stop+start same cycle -> stays IDLE.
REQ-038 rst_n low mid-PLAY -> all outputs 0 asynchronously; song_sel with rom_track=0 -> done 2 cycles after start, no tone.
REQ-039 SONG_LOOP_EN defined -> after note 41 of `little_star, rom_cnt returns to 0, done pulses, playback continues.

Source files
------------

// File: rtl/song_sequencer.sv
// Song sequencer: walks a song table note by note, sounding each note for its length minus a silent gap.
// Build option: define SONG_LOOP_EN to make a finished song restart from its first note until stopped.
`ifndef SONG_BITS
`define SONG_BITS 2
`endif
`ifndef SONG_CNT_BITS
`define SONG_CNT_BITS 8
`endif
`ifndef OCTAVE_BITS
`define OCTAVE_BITS 3
`endif
`ifndef NOTE_BITS
`define NOTE_BITS 4
`endif
`ifndef LENGTH_BITS
`define LENGTH_BITS 4
`endif

module song_sequencer #(
  parameter int unsigned UNIT_CYCLES = 2_500_000,
  parameter int unsigned GAP_CYCLES  = 250_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      pause,
  input  logic [`SONG_BITS-1:0]     song_sel,
  output logic [`SONG_BITS-1:0]     rom_song,
  output logic [`SONG_CNT_BITS-1:0] rom_cnt,
  input  logic [`SONG_CNT_BITS-1:0] rom_track,
  input  logic [`OCTAVE_BITS-1:0]   rom_octave,
  input  logic [`NOTE_BITS-1:0]     rom_note,
  input  logic [`LENGTH_BITS-1:0]   rom_length,
  output logic                      tone_valid,
  output logic [`OCTAVE_BITS-1:0]   tone_octave,
  output logic [`NOTE_BITS-1:0]     tone_note,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned SONG_W  = `SONG_BITS;
  localparam int unsigned CNT_W   = `SONG_CNT_BITS;
  localparam int unsigned OCT_W   = `OCTAVE_BITS;
  localparam int unsigned NOTE_W  = `NOTE_BITS;
  localparam int unsigned LEN_W   = `LENGTH_BITS;
  localparam int unsigned TIMER_W = LEN_W + 32;

  typedef enum logic [2:0] {IDLE, FETCH, PLAY, GAP, END} state_t;

  state_t              state, state_n;
  logic [TIMER_W-1:0]  timer, timer_n;
  logic [SONG_W-1:0]   song_n;
  logic [CNT_W-1:0]    cnt_n;
  logic [OCT_W-1:0]    oct_n;
  logic [NOTE_W-1:0]   note_n;
  logic                tone_valid_n;
  logic                busy_n;
  logic                done_n;

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      rom_song    <= '0;
      rom_cnt     <= '0;
      tone_octave <= '0;
      tone_note   <= '0;
      tone_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      rom_song    <= song_n;
      rom_cnt     <= cnt_n;
      tone_octave <= oct_n;
      tone_note   <= note_n;
      tone_valid  <= tone_valid_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    timer_n = timer;
    song_n  = rom_song;
    cnt_n   = rom_cnt;
    oct_n   = tone_octave;
    note_n  = tone_note;

    case (state)
      IDLE: begin
        if (start) begin
          song_n  = song_sel;
          cnt_n   = '0;
          state_n = FETCH;
        end
      end
      FETCH: begin
        if (rom_cnt >= rom_track) begin
          state_n = END;
        end else if (rom_length == '0) begin
          cnt_n = rom_cnt + CNT_W'(1);
        end else begin
          oct_n   = rom_octave;
          note_n  = rom_note;
          timer_n = TIMER_W'(rom_length) * TIMER_W'(UNIT_CYCLES) - TIMER_W'(GAP_CYCLES);
          state_n = PLAY;
        end
      end
      PLAY: begin
        if (!pause) begin
          if (timer <= TIMER_W'(1)) begin
            if (GAP_CYCLES == 0) begin
              cnt_n   = rom_cnt + CNT_W'(1);
              timer_n = '0;
              state_n = FETCH;
            end else begin
              timer_n = TIMER_W'(GAP_CYCLES);
              state_n = GAP;
            end
          end else begin
            timer_n = timer - TIMER_W'(1);
          end
        end
      end
      GAP: begin
        if (!pause) begin
          if (timer <= TIMER_W'(1)) begin
            cnt_n   = rom_cnt + CNT_W'(1);
            timer_n = '0;
            state_n = FETCH;
          end else begin
            timer_n = timer - TIMER_W'(1);
          end
        end
      end
      END: begin
`ifdef SONG_LOOP_EN
        cnt_n   = '0;
        state_n = FETCH;
`else
        state_n = IDLE;
`endif
      end
      default: state_n = IDLE;
    endcase

    // Abort overrides everything, including a simultaneous start
    if (stop) begin
      state_n = IDLE;
      timer_n = '0;
    end

    tone_valid_n = (state_n == PLAY) && !pause;
    busy_n       = (state_n != IDLE);
    done_n       = (state_n == END);
  end

endmodule
